// File: rtl/displays_pkg.sv
// displays_pkg: shared FSM states, display codes and the double-dabble adjust step.
package displays_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [3:0] SIGN_MINUS  = 4'hB;
  localparam logic [3:0] SIGN_BLANK  = 4'hF;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/bcd_dabble_core.sv
// bcd_dabble_core: iterative double-dabble, one magnitude bit per step; last flags the final step.
module bcd_dabble_core import displays_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [WIDTH-1:0]      mag,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  last
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0]    sh;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d+:4] = add3_if_ge5(bcd[4*d+:4]);
  end
  assign last = cnt == CW'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bcd <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      bcd <= '0;
      sh  <= mag;
      cnt <= CW'(WIDTH);
    end else if (step) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt - CW'(1);
    end
endmodule

// File: rtl/peripheral_deco7seg.sv
// peripheral_deco7seg: 4-bit code to active-high segments {g,f,e,d,c,b,a}; digits/minus or letters.
module peripheral_deco7seg (
  input  logic [3:0] code,
  input  logic       is_letter,
  output logic [6:0] seg
);
  logic [6:0] num_seg, let_seg;
  always_comb begin
    case (code)
      4'h0: num_seg = 7'h3F;
      4'h1: num_seg = 7'h06;
      4'h2: num_seg = 7'h5B;
      4'h3: num_seg = 7'h4F;
      4'h4: num_seg = 7'h66;
      4'h5: num_seg = 7'h6D;
      4'h6: num_seg = 7'h7D;
      4'h7: num_seg = 7'h07;
      4'h8: num_seg = 7'h7F;
      4'h9: num_seg = 7'h6F;
      4'hB: num_seg = 7'h40;
      default: num_seg = 7'h00;
    endcase
    case (code)
      4'h0: let_seg = 7'h77;
      4'h1: let_seg = 7'h7C;
      4'h2: let_seg = 7'h39;
      4'h3: let_seg = 7'h5E;
      4'h4: let_seg = 7'h79;
      4'h5: let_seg = 7'h71;
      4'h6: let_seg = 7'h76;
      4'h7: let_seg = 7'h38;
      4'h8: let_seg = 7'h73;
      4'h9: let_seg = 7'h3E;
      4'hA: let_seg = 7'h50;
      4'hB: let_seg = 7'h54;
      4'hC: let_seg = 7'h5C;
      4'hD: let_seg = 7'h78;
      4'hE: let_seg = 7'h6E;
      default: let_seg = 7'h00;
    endcase
  end
  assign seg = is_letter ? let_seg : num_seg;
endmodule

// File: rtl/displays_seq.sv
// displays_seq: registered sign-magnitude BCD display driver (letter, sign, DIGITS digits).
// Optional DISPLAYS_LEADING_ZERO_BLANK_EN blanks leading zero digits at commit.
module displays_seq import displays_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      num,
  input  logic [3:0]            letter,
  output logic                  busy,
  output logic                  done,
  output logic [6:0]            disp_letter,
  output logic [6:0]            disp_sign,
  output logic [7*DIGITS-1:0]   disp_digits
);
  if ((64'd10 ** DIGITS) <= (64'd1 << WIDTH)) begin : g_bad_size
    $error("displays_seq: DIGITS too small for WIDTH");
  end
  state_t              state, state_nx;
  logic                neg, neg_q, load, last;
  logic [WIDTH-1:0]    mag;
  logic [3:0]          letter_q, letter_c, sign_c;
  logic [4*DIGITS-1:0] bcd, dig_c, dig_nx;
  always_comb begin
    state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
               (state == SHIFT) ? (last ? COMMIT : SHIFT) : IDLE;
  end
  assign load = (state == IDLE) && start;
  assign busy = state != IDLE;
  assign done = state == COMMIT;
  assign neg  = (SIGNED != 0) && num[WIDTH-1];
  assign mag  = neg ? ~num + WIDTH'(1) : num;
  bcd_dabble_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_core (
    .clk(clk), .reset(reset), .load(load), .step(state == SHIFT),
    .mag(mag), .bcd(bcd), .last(last)
  );
`ifdef DISPLAYS_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    seen   = 1'b0;
    dig_nx = bcd;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen = seen | (bcd[4*i+:4] != 4'd0);
      if (!seen) dig_nx[4*i+:4] = DIGIT_BLANK;
    end
  end
`else
  assign dig_nx = bcd;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      letter_q <= '0;
      neg_q    <= 1'b0;
      letter_c <= '0;
      sign_c   <= SIGN_BLANK;
      dig_c    <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        letter_q <= letter;
        neg_q    <= neg;
      end
      if (done) begin
        letter_c <= letter_q;
        sign_c   <= neg_q ? SIGN_MINUS : SIGN_BLANK;
        dig_c    <= dig_nx;
      end
    end
  peripheral_deco7seg u_letter (.code(letter_c), .is_letter(1'b1), .seg(disp_letter));
  peripheral_deco7seg u_sign   (.code(sign_c),   .is_letter(1'b0), .seg(disp_sign));
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    peripheral_deco7seg u_dig (.code(dig_c[4*d+:4]), .is_letter(1'b0), .seg(disp_digits[7*d+:7]));
  end
endmodule

// File: tb/tb_displays_seq.sv
// tb_displays_seq: table-driven vectors plus hand sequences over three parameterisations.
module tb_displays_seq;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] letter = '0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [7:0] num0 = '0, num2 = '0;
  logic [11:0] num1 = '0;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [6:0] dl0, dl1, dl2, ds0, ds1, ds2;
  logic [20:0] dd0, dd2;
  logic [27:0] dd1;
  int vec = 0, bad = 0;
  always #5 clk = ~clk;

  displays_seq u_dut0 (.clk(clk), .reset(reset), .start(start0), .num(num0), .letter(letter),
    .busy(busy0), .done(done0), .disp_letter(dl0), .disp_sign(ds0), .disp_digits(dd0));
  displays_seq #(.WIDTH(12), .DIGITS(4), .SIGNED(1)) u_dut1 (.clk(clk), .reset(reset), .start(start1),
    .num(num1), .letter(letter), .busy(busy1), .done(done1), .disp_letter(dl1), .disp_sign(ds1),
    .disp_digits(dd1));
  displays_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_dut2 (.clk(clk), .reset(reset), .start(start2),
    .num(num2), .letter(letter), .busy(busy2), .done(done2), .disp_letter(dl2), .disp_sign(ds2),
    .disp_digits(dd2));

  function automatic logic [6:0] sd(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hB: return 7'h40; default: return 7'h00;
    endcase
  endfunction
  function automatic logic [6:0] sl(input logic [3:0] c);
    case (c)
      4'h0: return 7'h77; 4'h1: return 7'h7C; 4'h2: return 7'h39; 4'h3: return 7'h5E;
      4'h4: return 7'h79; 4'h5: return 7'h71; 4'h6: return 7'h76; 4'h7: return 7'h38;
      4'h8: return 7'h73; 4'h9: return 7'h3E; 4'hA: return 7'h50; 4'hB: return 7'h54;
      4'hC: return 7'h5C; 4'hD: return 7'h78; 4'hE: return 7'h6E; default: return 7'h00;
    endcase
  endfunction
  // expected digit segments from raw decimal digits (leading-zero blanking when built with it)
  function automatic logic [27:0] ed(input int nd, input logic [15:0] codes);
    logic [27:0] r;
    logic [3:0] c;
`ifdef DISPLAYS_LEADING_ZERO_BLANK_EN
    bit seen;
    seen = 0;
`endif
    r = '0;
    for (int i = nd - 1; i >= 0; i--) begin
      c = codes[4*i+:4];
`ifdef DISPLAYS_LEADING_ZERO_BLANK_EN
      seen = seen || (c != 4'd0);
      if (!seen && i > 0) c = 4'hF;
`endif
      r[7*i+:7] = sd(c);
    end
    return r;
  endfunction

  function automatic logic cur_busy(input int s);
    return s == 0 ? busy0 : s == 1 ? busy1 : busy2;
  endfunction
  function automatic logic cur_done(input int s);
    return s == 0 ? done0 : s == 1 ? done1 : done2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic convert(input int s, input logic [11:0] n, input logic [3:0] l,
                         output int bc, output int dat, output int dn);
    @(negedge clk);
    letter = l;
    if (s == 0) begin num0 = n[7:0]; start0 = 1'b1; end
    else if (s == 1) begin num1 = n; start1 = 1'b1; end
    else begin num2 = n[7:0]; start2 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bc = 0; dat = 0; dn = 0;
    while (cur_busy(s) && bc < 40) begin
      bc++;
      if (cur_done(s)) begin dn++; dat = bc; end
      @(negedge clk);
    end
  endtask

  typedef struct { logic [7:0] n; logic [3:0] l; logic neg; logic [11:0] d; } vec_t;
  vec_t tv[10];

  initial begin
    int bc, dat, dn, cnt;
    tv[0] = '{8'd123, 4'hA, 1'b0, 12'h123};
    tv[1] = '{8'h80,  4'h1, 1'b1, 12'h128};
    tv[2] = '{8'hFF,  4'h2, 1'b1, 12'h001};
    tv[3] = '{8'h00,  4'h3, 1'b0, 12'h000};
    tv[4] = '{8'd7,   4'h4, 1'b0, 12'h007};
    tv[5] = '{8'h7F,  4'h5, 1'b0, 12'h127};
    tv[6] = '{8'h81,  4'h6, 1'b1, 12'h127};
    tv[7] = '{8'd100, 4'h7, 1'b0, 12'h100};
    tv[8] = '{8'h9C,  4'hE, 1'b1, 12'h100};
    tv[9] = '{8'hF6,  4'hF, 1'b1, 12'h010};
    repeat (2) @(negedge clk);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_letter", dl0, 7'h77);
    chk("reset_sign", ds0, 7'h00);
    chk("reset_digits", dd0, {3{7'h3F}});
    chk("reset_digits_w12", dd1, {4{7'h3F}});
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      convert(0, {4'b0, tv[i].n}, tv[i].l, bc, dat, dn);
      chk($sformatf("v%0d_busy_cycles", i), bc, 9);
      chk($sformatf("v%0d_done_at", i), dat, 9);
      chk($sformatf("v%0d_done_count", i), dn, 1);
      chk($sformatf("v%0d_letter", i), dl0, sl(tv[i].l));
      chk($sformatf("v%0d_sign", i), ds0, tv[i].neg ? 7'h40 : 7'h00);
      chk($sformatf("v%0d_digits", i), dd0, ed(3, {4'b0, tv[i].d}));
    end

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    num0 = 8'd45; letter = 4'h3; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    dn = 0; cnt = 0;
    repeat (2) begin cnt++; if (done0) dn++; @(negedge clk); end
    num0 = 8'd99; letter = 4'h9; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (busy0 && cnt < 40) begin cnt++; if (done0) dn++; @(negedge clk); end
    chk("busy_start_done_count", dn, 1);
    chk("busy_start_digits", dd0, ed(3, 16'h045));
    chk("busy_start_letter", dl0, sl(4'h3));
    repeat (12) begin if (busy0 || done0) dn++; @(negedge clk); end
    chk("busy_start_not_queued", dn, 1);

    // start held through COMMIT: next conversion starts right after done
    num0 = 8'd123; letter = 4'h1; start0 = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!done0 && cnt < 40) begin cnt++; @(negedge clk); end
    chk("hold_done_seen", done0, 1);
    @(negedge clk);
    chk("hold_idle_gap_busy", busy0, 0);
    chk("hold_first_digits", dd0, ed(3, 16'h123));
    num0 = 8'd45;
    @(negedge clk);
    chk("hold_second_busy", busy0, 1);
    start0 = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 40) begin cnt++; @(negedge clk); end
    chk("hold_second_digits", dd0, ed(3, 16'h045));

    convert(1, 12'h800, 4'h2, bc, dat, dn);
    chk("w12_busy_cycles", bc, 13);
    chk("w12_done_at", dat, 13);
    chk("w12_sign", ds1, 7'h40);
    chk("w12_digits", dd1, ed(4, 16'h2048));
    chk("w12_letter", dl1, sl(4'h2));
    convert(1, 12'h7FF, 4'h4, bc, dat, dn);
    chk("w12_max_sign", ds1, 7'h00);
    chk("w12_max_digits", dd1, ed(4, 16'h2047));

    convert(2, 12'h0FF, 4'h5, bc, dat, dn);
    chk("uns_busy_cycles", bc, 9);
    chk("uns_sign", ds2, 7'h00);
    chk("uns_digits", dd2, ed(3, 16'h255));
    convert(2, 12'h080, 4'h5, bc, dat, dn);
    chk("uns_80_sign", ds2, 7'h00);
    chk("uns_80_digits", dd2, ed(3, 16'h128));

    // async reset in the middle of a conversion discards everything
    convert(0, 12'h0F6, 4'h8, bc, dat, dn);
    chk("pre_reset_sign", ds0, 7'h40);
    @(negedge clk);
    num0 = 8'd123; letter = 4'hC; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_done", done0, 0);
    chk("midrst_letter", dl0, 7'h77);
    chk("midrst_sign", ds0, 7'h00);
    chk("midrst_digits", dd0, {3{7'h3F}});
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (15) begin if (busy0 || done0) dn++; @(negedge clk); end
    chk("midrst_no_done", dn, 0);
    chk("midrst_digits_hold", dd0, {3{7'h3F}});

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
